button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner_pkg.sv | 25 ++
 rtl/sync_2ff.sv | 34 +++
 rtl/button_conditioner.sv | 139 +++++++++++++
 tb/tb_button_conditioner.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/button_conditioner_pkg.sv
// ============================================================================
// Module      : button_conditioner_pkg
// Description : Shared game parameters: debounce/hold defaults, FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package button_conditioner_pkg;

    localparam int unsigned c_DEBOUNCE_CYCLES_DEFAULT = 1_000_000;
    localparam int unsigned c_HOLD_CYCLES_DEFAULT     = 100_000_000;

    localparam logic [1:0] c_ST_IDLE        = 2'd0;
    localparam logic [1:0] c_ST_DEB_PRESS   = 2'd1;
    localparam logic [1:0] c_ST_HELD        = 2'd2;
    localparam logic [1:0] c_ST_DEB_RELEASE = 2'd3;

    // A counter for n states still needs one bit when n is 1 or 2.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer for asynchronous board inputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset_in,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clock or negedge reset_in) begin
        if (!reset_in) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/button_conditioner.sv
// ============================================================================
// Module      : button_conditioner
// Description : Debounces a DE0 pushbutton; press/release/long-press strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned HOLD_CYCLES     = c_HOLD_CYCLES_DEFAULT
) (
    input  logic clock,
    input  logic reset_in,
    input  logic key_n,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press,
    output logic reset_request
);

    localparam int unsigned         c_CNT_W     = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned         c_HOLD_W    = cnt_width(HOLD_CYCLES);
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST  = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES - 1);

    // Invert ahead of the synchronizer so its cleared flops read as "released".
    logic w_key_raw;
    logic w_key_sync;

    assign w_key_raw = ~key_n;

    sync_2ff #(.WIDTH(1)) u_sync (
        .clock    (clock),
        .reset_in (reset_in),
        .i_d      (w_key_raw),
        .o_q      (w_key_sync)
    );

    logic [1:0]          r_state,         w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt,           w_cnt_nxt;
    logic [c_HOLD_W-1:0] r_hold_cnt,      w_hold_cnt_nxt;
    logic                r_pressed,       w_pressed_nxt;
    logic                r_press_pulse,   w_press_pulse_nxt;
    logic                r_release_pulse, w_release_pulse_nxt;
    logic                r_long_press,    w_long_press_nxt;
    logic                r_reset_request, w_reset_request_nxt;

    always_ff @(posedge clock or negedge reset_in) begin
        if (!reset_in) begin
            r_state         <= c_ST_IDLE;
            r_cnt           <= '0;
            r_hold_cnt      <= '0;
            r_pressed       <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_long_press    <= 1'b0;
            r_reset_request <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_hold_cnt      <= w_hold_cnt_nxt;
            r_pressed       <= w_pressed_nxt;
            r_press_pulse   <= w_press_pulse_nxt;
            r_release_pulse <= w_release_pulse_nxt;
            r_long_press    <= w_long_press_nxt;
            r_reset_request <= w_reset_request_nxt;
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_cnt_nxt           = r_cnt;
        w_hold_cnt_nxt      = r_hold_cnt;
        w_pressed_nxt       = r_pressed;
        w_reset_request_nxt = r_reset_request;
        w_press_pulse_nxt   = 1'b0;
        w_release_pulse_nxt = 1'b0;
        w_long_press_nxt    = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (w_key_sync) begin
                    w_state_nxt = c_ST_DEB_PRESS;
                    w_cnt_nxt   = '0;
                end
            end
            c_ST_DEB_PRESS: begin
                if (!w_key_sync) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt       = c_ST_HELD;
                    w_press_pulse_nxt = 1'b1;
                    w_pressed_nxt     = 1'b1;
                    w_hold_cnt_nxt    = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            c_ST_HELD: begin
                // reset_request doubles as the one-long-press-per-press latch.
                if ((r_hold_cnt == c_HOLD_LAST) && !r_reset_request) begin
                    w_long_press_nxt    = 1'b1;
                    w_reset_request_nxt = 1'b1;
                end
                if (!w_key_sync) begin
                    w_state_nxt = c_ST_DEB_RELEASE;
                    w_cnt_nxt   = '0;
                end else if (r_hold_cnt != c_HOLD_LAST) begin
                    w_hold_cnt_nxt = r_hold_cnt + c_HOLD_W'(1);
                end
            end
            c_ST_DEB_RELEASE: begin
                if (w_key_sync) begin
                    w_state_nxt = c_ST_HELD;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt         = c_ST_IDLE;
                    w_release_pulse_nxt = 1'b1;
                    w_pressed_nxt       = 1'b0;
                    w_reset_request_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    assign pressed       = r_pressed;
    assign press_pulse   = r_press_pulse;
    assign release_pulse = r_release_pulse;
    assign long_press    = r_long_press;
    assign reset_request = r_reset_request;

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
// ============================================================================
// Module      : tb_button_conditioner
// Description : Self-checking bench for button_conditioner (D=4, H=16).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_conditioner;

    localparam int unsigned c_D = 4;
    localparam int unsigned c_H = 16;

    logic clock;
    logic reset_in;
    logic key_n;
    logic pressed;
    logic press_pulse;
    logic release_pulse;
    logic long_press;
    logic reset_request;

    int checks   = 0;
    int failures = 0;

    button_conditioner #(
        .DEBOUNCE_CYCLES (c_D),
        .HOLD_CYCLES     (c_H)
    ) dut (
        .clock         (clock),
        .reset_in      (reset_in),
        .key_n         (key_n),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_press    (long_press),
        .reset_request (reset_request)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the debounced level flips once D+1 consecutive
    // synchronized samples disagree with it; the hold count grows on each
    // pair of consecutive "down" samples seen while the button is accepted.
    bit h1, h2, lvl, prev, m_pp, m_rp, m_lp, m_rr;
    int run, hold;

    task automatic model_step();
        bit s;
        if (!reset_in) begin
            {h1, h2, lvl, prev, m_pp, m_rp, m_lp, m_rr} = '0;
            run  = 0;
            hold = 0;
        end else begin
            s  = h2;
            h2 = h1;
            h1 = ~key_n;
            m_pp = 0; m_rp = 0; m_lp = 0;
            if (lvl && prev && hold >= int'(c_H) - 1 && !m_rr) begin
                m_lp = 1;
                m_rr = 1;
            end
            if (lvl && prev && s) hold++;
            if (s != lvl) run++; else run = 0;
            if (run == int'(c_D) + 1) begin
                lvl = s;
                run = 0;
                if (s) begin
                    m_pp = 1;
                    hold = 0;
                end else begin
                    m_rp = 1;
                    m_rr = 0;
                end
            end
            prev = s;
        end
    endtask

    initial forever begin
        @(posedge clock or negedge reset_in);
        model_step();
    end

    int n_press = 0, n_release = 0, n_long = 0;

    initial forever begin
        @(negedge clock);
        if (!reset_in)
            chk("model", {pressed, press_pulse, release_pulse, long_press, reset_request}, 32'h0);
        else
            chk("model", {pressed, press_pulse, release_pulse, long_press, reset_request},
                {lvl, m_pp, m_rp, m_lp, m_rr});
        chk("pulse_exclusive", 32'($countones({press_pulse, release_pulse, long_press}) <= 1), 1);
        n_press   += int'(press_pulse);
        n_release += int'(release_pulse);
        n_long    += int'(long_press);
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clock);
    endtask

    int base_press, base_long, base_release;

    initial begin
        reset_in = 1'b0;
        key_n    = 1'b1;
        wait_neg(3);
        chk("reset_outputs", {pressed, press_pulse, release_pulse, long_press, reset_request}, 0);
        reset_in = 1'b1;
        wait_neg(5);

        // Clean press and long press
        key_n = 1'b0;
        wait_neg(6);  chk("clean_press_early", press_pulse, 0);
        wait_neg(1);  chk("clean_press_pulse", press_pulse, 1); chk("clean_pressed", pressed, 1);
        wait_neg(15); chk("clean_long_early", long_press, 0); chk("clean_rr_early", reset_request, 0);
        wait_neg(1);  chk("clean_long_pulse", long_press, 1); chk("clean_rr", reset_request, 1);
        wait_neg(1);  chk("clean_long_once", long_press, 0); chk("clean_rr_hold", reset_request, 1);
        key_n = 1'b1;
        wait_neg(6);  chk("clean_rel_early", release_pulse, 0); chk("clean_rr_pre_rel", reset_request, 1);
        wait_neg(1);  chk("clean_rel_pulse", release_pulse, 1); chk("clean_rel_pressed", pressed, 0);
        chk("clean_rr_cleared", reset_request, 0);
        wait_neg(5);

        // Press bounce
        #1 base_press = n_press;
        key_n = 1'b0; wait_neg(3);
        key_n = 1'b1; wait_neg(1);
        key_n = 1'b0;
        wait_neg(6);  #1 chk("bounce_no_pulse", n_press - base_press, 0);
        chk("bounce_press_early", press_pulse, 0);
        wait_neg(1);  chk("bounce_press_pulse", press_pulse, 1);

        // Release bounce after 10 held cycles, no long press
        #1 base_long = n_long; base_release = n_release;
        wait_neg(10);
        key_n = 1'b1; wait_neg(2);
        key_n = 1'b0; wait_neg(2);
        key_n = 1'b1;
        wait_neg(6);  #1 chk("relb_no_release", n_release - base_release, 0);
        chk("relb_still_pressed", pressed, 1);
        wait_neg(1);  chk("relb_release_pulse", release_pulse, 1); chk("relb_pressed", pressed, 0);
        wait_neg(3);  #1 chk("relb_release_count", n_release - base_release, 1);
        chk("relb_no_long", n_long - base_long, 0);
        wait_neg(4);

        // Hold 40 cycles then release
        #1 base_long = n_long;
        key_n = 1'b0;
        wait_neg(7);  chk("hold40_press", press_pulse, 1);
        wait_neg(33); chk("hold40_rr", reset_request, 1);
        key_n = 1'b1;
        wait_neg(6);  chk("hold40_rr_pre_rel", reset_request, 1);
        wait_neg(1);  chk("hold40_rel_pulse", release_pulse, 1); chk("hold40_rr_drop", reset_request, 0);
        wait_neg(3);  #1 chk("hold40_long_count", n_long - base_long, 1);
        wait_neg(4);

        // Asynchronous reset during HELD with reset_request set
        key_n = 1'b0;
        wait_neg(25); chk("rst_pre_rr", reset_request, 1); chk("rst_pre_pressed", pressed, 1);
        #2 reset_in = 1'b0;
        #1 chk("rst_async_outputs", {pressed, press_pulse, release_pulse, long_press, reset_request}, 0);
        wait_neg(2);
        reset_in = 1'b1;
        wait_neg(6);  chk("rst_redeb_early", press_pulse, 0); chk("rst_redeb_not_pressed", pressed, 0);
        wait_neg(1);  chk("rst_redeb_pulse", press_pulse, 1); chk("rst_redeb_pressed", pressed, 1);
        key_n = 1'b1;
        wait_neg(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
